// File: rtl/d_input_debouncer.sv
// Two-flop (or deeper) synchroniser followed by a counter-qualified level FSM.
// Q changes only after s has held the new level for DB_CYCLES consecutive edges.
module d_input_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  localparam int CW         = $clog2(DB_CYCLES + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          D_raw,
  output logic          Q,
  output logic          Qbar,
  output logic          rise,
  output logic          fall,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_cnt
);

  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          q_n, rise_n, fall_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], D_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Pulses default low so each accept edge produces exactly one cycle of rise/fall.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = Q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_LOW: begin
        cnt_n = '0;
        if (s) begin
          if (CNT_LAST == '0) begin
            state_n = ST_HIGH;
            q_n     = 1'b1;
            rise_n  = 1'b1;
          end else begin
            state_n = WAIT_HIGH;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = ST_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HIGH;
          q_n     = 1'b1;
          rise_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        cnt_n = '0;
        if (!s) begin
          if (CNT_LAST == '0) begin
            state_n = ST_LOW;
            q_n     = 1'b0;
            fall_n  = 1'b1;
          end else begin
            state_n = WAIT_LOW;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = ST_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_LOW;
          q_n     = 1'b0;
          fall_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_LOW;
      cnt   <= '0;
      Q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Q     <= q_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  assign Qbar      = ~Q;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_d_input_debouncer.sv
// Bench for d_input_debouncer: three instances (DB_CYCLES 4, 1, 16); expected pulses
// are queued with their edge number and popped by a negedge monitor.
module tb_d_input_debouncer;

  logic CLK = 1'b0;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic rst_a = 1'b0, d_a = 1'b0, q_a, qb_a, rise_a, fall_a;
  logic rst_b = 1'b0, d_b = 1'b0, q_b, qb_b, rise_b, fall_b;
  logic rst_c = 1'b0, d_c = 1'b0, q_c, qb_c, rise_c, fall_c;
  logic [1:0] st_a, st_b, st_c;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
  logic [4:0] cnt_c;

  d_input_debouncer #(.SYNC_STAGES(2), .DB_CYCLES(4)) u_a (
    .CLK(CLK), .RST(rst_a), .D_raw(d_a), .Q(q_a), .Qbar(qb_a),
    .rise(rise_a), .fall(fall_a), .dbg_state(st_a), .dbg_cnt(cnt_a));

  d_input_debouncer #(.SYNC_STAGES(2), .DB_CYCLES(1)) u_b (
    .CLK(CLK), .RST(rst_b), .D_raw(d_b), .Q(q_b), .Qbar(qb_b),
    .rise(rise_b), .fall(fall_b), .dbg_state(st_b), .dbg_cnt(cnt_b));

  d_input_debouncer u_c (
    .CLK(CLK), .RST(rst_c), .D_raw(d_c), .Q(q_c), .Qbar(qb_c),
    .rise(rise_c), .fall(fall_c), .dbg_state(st_c), .dbg_cnt(cnt_c));

  // Scoreboard entry: {instance[1:0], is_fall, edge_number[15:0]}
  logic [18:0] exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_q [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] id, input logic is_fall, input int edge_n);
    logic [15:0] e16;
    e16 = edge_n[15:0];
    exp_q.push_back({id, is_fall, e16});
  endtask

  // Returns just after the negedge that follows posedge n, so inputs driven now
  // are first sampled at edge n+1.
  task automatic at_cycle(input int n);
    @(negedge CLK);
    while (cyc < n) @(negedge CLK);
    #1;
  endtask

  task automatic mon(input logic [1:0] id, input logic rst, input logic q, input logic qb,
                     input logic r, input logic f, input logic [4:0] cnt, input int db);
    logic [18:0] got, e;
    logic [15:0] c16;
    if (!rst) begin
      prev_q[id] = q;
      return;
    end
    chk("qbar_inv", {31'b0, qb}, {31'b0, ~q});
    chk("rise_and_fall", {31'b0, r & f}, 32'd0);
    n_vec++;
    if (int'(cnt) > db - 1) begin
      n_err++;
      $display("FAIL cnt_bound inst %0d @edge %0d: got %0d limit %0d", id, cyc, cnt, db - 1);
    end
    if (r || f) begin
      c16 = cyc[15:0];
      got = {id, f, c16};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL pulse: got inst %0d fall %0b edge %0d expected inst %0d fall %0b edge %0d",
                   got[18:17], got[16], got[15:0], e[18:17], e[16], e[15:0]);
        end
      end
      chk("q_with_pulse", {31'b0, q}, {31'b0, r});
      chk("q_toggled", {31'b0, q}, {31'b0, ~prev_q[id]});
    end else begin
      chk("q_steady_no_pulse", {31'b0, q}, {31'b0, prev_q[id]});
    end
    prev_q[id] = q;
  endtask

  always @(negedge CLK) begin
    mon(2'd0, rst_a, q_a, qb_a, rise_a, fall_a, {2'b0, cnt_a}, 4);
    mon(2'd1, rst_b, q_b, qb_b, rise_b, fall_b, {4'b0, cnt_b}, 1);
    mon(2'd2, rst_c, q_c, qb_c, rise_c, fall_c, cnt_c, 16);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nruns;
    logic lvl, qm;

    // Reset values while held in reset
    @(negedge CLK); #1;
    chk("rst_q_a", {31'b0, q_a}, 32'd0);
    chk("rst_qbar_a", {31'b0, qb_a}, 32'd1);
    chk("rst_pulses_a", {30'b0, rise_a, fall_a}, 32'd0);
    chk("rst_state_a", {30'b0, st_a}, 32'd0);
    chk("rst_qbar_b", {31'b0, qb_b}, 32'd1);
    chk("rst_state_b", {30'b0, st_b}, 32'd0);
    chk("rst_qbar_c", {31'b0, qb_c}, 32'd1);
    chk("rst_state_c", {30'b0, st_c}, 32'd0);
    at_cycle(2);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Clean rise then clean fall: first sample at 10 -> edge 15; at 30 -> edge 35
    at_cycle(9);  d_a = 1'b1; expect_pulse(2'd0, 1'b0, 15);
    at_cycle(15); chk("clean_rise_q", {31'b0, q_a}, 32'd1);
                  chk("clean_rise_pulse", {31'b0, rise_a}, 32'd1);
    at_cycle(16); chk("clean_rise_pulse_end", {31'b0, rise_a}, 32'd0);
    at_cycle(29); d_a = 1'b0; expect_pulse(2'd0, 1'b1, 35);
    at_cycle(34); chk("clean_fall_before", {31'b0, q_a}, 32'd1);
    at_cycle(35); chk("clean_fall_q", {31'b0, q_a}, 32'd0);
                  chk("clean_fall_pulse", {31'b0, fall_a}, 32'd1);

    // Bounce: high 46..48, low 49 (lands on the accept edge), high from 50 -> edge 55
    at_cycle(45); d_a = 1'b1;
    at_cycle(48); d_a = 1'b0;
    at_cycle(49); d_a = 1'b1; expect_pulse(2'd0, 1'b0, 55);
    at_cycle(51); chk("bounce_aborted_state", {30'b0, st_a}, 32'd0);
    at_cycle(54); chk("bounce_no_early_q", {31'b0, q_a}, 32'd0);
    at_cycle(55); chk("bounce_late_rise", {31'b0, q_a}, 32'd1);

    // Asynchronous reset mid-cycle while Q=1, D_raw still held high
    at_cycle(60);
    #2 rst_a = 1'b0;
    #1;
    chk("async_rst_q", {31'b0, q_a}, 32'd0);
    chk("async_rst_qbar", {31'b0, qb_a}, 32'd1);
    chk("async_rst_pulses", {30'b0, rise_a, fall_a}, 32'd0);
    chk("async_rst_cnt", {29'b0, cnt_a}, 32'd0);
    // Release edge 63 -> rise at 63+5
    at_cycle(62); rst_a = 1'b1; expect_pulse(2'd0, 1'b0, 68);
    at_cycle(67); chk("post_rst_no_early", {31'b0, q_a}, 32'd0);
    at_cycle(68); chk("post_rst_rise", {31'b0, q_a}, 32'd1);

    // Reset pulse during WAIT_HIGH: release edge 94 -> rise at 99 instead of 95
    at_cycle(75); d_a = 1'b0; expect_pulse(2'd0, 1'b1, 81);
    at_cycle(89); d_a = 1'b1;
    at_cycle(93);
    chk("mid_wait_state", {30'b0, st_a}, 32'd1);
    rst_a = 1'b0;
    #1 chk("mid_wait_rst_cnt", {29'b0, cnt_a}, 32'd0);
    #1 rst_a = 1'b1;
    expect_pulse(2'd0, 1'b0, 99);
    at_cycle(95); chk("mid_wait_aborted", {31'b0, q_a}, 32'd0);
    at_cycle(99); chk("mid_wait_rise", {31'b0, q_a}, 32'd1);
    at_cycle(110); d_a = 1'b0; expect_pulse(2'd0, 1'b1, 116);

    // DB_CYCLES=1: Q follows D_raw two edges later, toggling every 3 cycles
    for (int i = 0; i < 6; i++) begin
      at_cycle(119 + 3 * i);
      chk("min_db_follow", {31'b0, q_b}, {31'b0, d_b});
      d_b = ~d_b;
      expect_pulse(2'd1, ~d_b, 122 + 3 * i);
    end

    // Defaults: random bounce bursts (runs 1..8) then 20-cycle holds
    t = 150; lvl = 1'b0; qm = 1'b0;
    for (int r = 0; r < 8; r++) begin
      nruns = $urandom_range(1, 6);
      for (int j = 0; j < nruns; j++) begin
        at_cycle(t);
        if (j == 0) chk("hold_level", {31'b0, q_c}, {31'b0, qm});
        lvl = ~lvl; d_c = lvl;
        t = t + $urandom_range(1, 8);
      end
      at_cycle(t);
      lvl = ~lvl; d_c = lvl;
      if (lvl != qm) begin
        expect_pulse(2'd2, ~lvl, t + 1 + 17);
        qm = lvl;
      end
      t = t + 20;
    end
    at_cycle(t);
    chk("final_hold_level", {31'b0, q_c}, {31'b0, qm});
    at_cycle(t + 3);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
